// File: rtl/bus_responder_ram_if.sv
// Bus between the initiator (bus interface unit) and a target responder.
// The initiator drives the request; the target returns ready/data/busy/error.
interface bus_responder_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  bus_vaild;
  logic                  bus_write_enable;
  logic [ADDR_WIDTH-1:0] bus_address;
  logic [DATA_WIDTH-1:0] bus_data_write;
  logic                  bus_ready;
  logic [DATA_WIDTH-1:0] bus_data_read;
  logic                  bus_busy;
  logic                  bus_error;

  // Initiator side: issues requests, observes completion.
  modport master (
    output bus_vaild,
    output bus_write_enable,
    output bus_address,
    output bus_data_write,
    input  bus_ready,
    input  bus_data_read,
    input  bus_busy,
    input  bus_error
  );

  // Target side: samples requests, produces completion.
  modport slave (
    input  bus_vaild,
    input  bus_write_enable,
    input  bus_address,
    input  bus_data_write,
    output bus_ready,
    output bus_data_read,
    output bus_busy,
    output bus_error
  );

endinterface

// File: rtl/bus_responder_ram.sv
// Target-side bus responder backed by a word-addressed RAM window.
// A request is latched at accept, held for WAIT_STATES cycles, then completed
// with a one-cycle ready pulse. Addresses outside the window still complete
// (with bus_error) so the initiator can never hang.
module bus_responder_ram #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int unsigned           WAIT_STATES  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_responder_ram_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  // Window bounds carry one extra bit so a window ending at the top of the
  // address space does not wrap.
  localparam logic [ADDR_WIDTH:0] WINDOW_LO = {1'b0, BASE_ADDRESS};
  localparam logic [ADDR_WIDTH:0] WINDOW_HI =
    WINDOW_LO + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  in_range_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  error_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Values captured at accept, derived from the live request.
  logic [ADDR_WIDTH:0]   addr_ext;
  logic                  in_range_d;
  logic [IDX_W-1:0]      idx_d;

  assign addr_ext   = {1'b0, bus.bus_address};
  assign in_range_d = (addr_ext >= WINDOW_LO) && (addr_ext < WINDOW_HI);
  // BASE_ADDRESS is window-aligned, so the offset's word index is simply the
  // address bits just above the byte lane.
  assign idx_d      = bus.bus_address[IDX_W+1:2];

  // The access completes on the edge where WAIT has run its count down and the
  // initiator is still requesting.
  logic access_fire;
  logic ram_write;

  assign access_fire = (state_q == S_WAIT) && bus.bus_vaild && (cnt_q == 4'd0);
  assign ram_write   = access_fire && we_q && in_range_q;

  // RAM write port: commits an in-range write on the edge that raises ready.
  // NOTE: the RAM array has no reset; its contents are defined only by writes,
  // and a reset term would prevent mapping it onto a memory macro.
  always_ff @(posedge clock) begin
    if (ram_write) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Transaction FSM with registered bus outputs.
  // NOTE: every register here uses <= so all of them see pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      in_range_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.bus_vaild) begin
            we_q       <= bus.bus_write_enable;
            idx_q      <= idx_d;
            wdata_q    <= bus.bus_data_write;
            in_range_q <= in_range_d;
            cnt_q      <= WAIT_INIT;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!bus.bus_vaild) begin
            // Initiator withdrew the request: abandon without any access.
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            ready_q <= 1'b1;
            error_q <= !in_range_q;
            if (!we_q) begin
              rdata_q <= in_range_q ? mem[idx_q] : '1;
            end
            state_q <= S_ACK;
          end
        end

        S_ACK: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= S_RELEASE;
        end

        S_RELEASE: begin
          // A slow initiator may keep vaild high after ready; wait it out so
          // the same request is never served twice.
          if (!bus.bus_vaild) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_ready     = ready_q;
  assign bus.bus_busy      = busy_q;
  assign bus.bus_error     = error_q;
  assign bus.bus_data_read = rdata_q;

endmodule

// File: tb/tb_bus_responder_ram.sv
// Directed bench for bus_responder_ram: scoreboard of expected completions,
// compared at each ready pulse, plus latency, abort and reset scenarios.
module tb_bus_responder_ram;

  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bus_responder_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  bus_responder_ram #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDRESS(BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_read;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + DEPTH * 4);
  endfunction

  // Reference model: updates bench RAM and predicts the completion.
  task automatic push_expected(input bit we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    idx = int'((addr - BASE) >> 2);
    e.err = !in_window(addr);
    if (we) begin
      if (in_window(addr)) model_mem[idx] = data;
      e.data = last_read;
    end else begin
      e.data = in_window(addr) ? model_mem[idx] : 32'hFFFF_FFFF;
      last_read = e.data;
    end
    sb_q.push_back(e);
  endtask

  // One full transaction; hold = extra cycles vaild stays high after ready.
  task automatic access(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] data, input int hold);
    int   cycles;
    exp_t e;
    push_expected(we, addr, data);
    @(negedge clock);
    bus_if.bus_vaild        = 1'b1;
    bus_if.bus_write_enable = we;
    bus_if.bus_address      = addr;
    bus_if.bus_data_write   = data;
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
      if (cycles == 1) begin
        check({tag, "_busy_accept"}, {31'b0, bus_if.bus_busy}, 32'd1);
        // Request fields must have been captured at accept.
        bus_if.bus_write_enable = ~we;
        bus_if.bus_address      = ~addr;
        bus_if.bus_data_write   = ~data;
      end
    end while (!bus_if.bus_ready && cycles < 30);
    check({tag, "_ready"}, {31'b0, bus_if.bus_ready}, 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(WS + 2));
    e = sb_q.pop_front();
    check({tag, "_data"}, bus_if.bus_data_read, e.data);
    check({tag, "_error"}, {31'b0, bus_if.bus_error}, {31'b0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({tag, "_ready_hold"}, {31'b0, bus_if.bus_ready}, 32'd0);
      check({tag, "_busy_hold"}, {31'b0, bus_if.bus_busy}, 32'd1);
    end
    bus_if.bus_vaild = 1'b0;
    if (hold == 0) begin
      @(negedge clock);
      check({tag, "_ready_width"}, {31'b0, bus_if.bus_ready}, 32'd0);
      check({tag, "_busy_ack"}, {31'b0, bus_if.bus_busy}, 32'd1);
    end
    @(negedge clock);
    check({tag, "_busy_release"}, {31'b0, bus_if.bus_busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                   = 1'b0;
    bus_if.bus_vaild        = 1'b0;
    bus_if.bus_write_enable = 1'b0;
    bus_if.bus_address      = '0;
    bus_if.bus_data_write   = '0;
    last_read               = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", {31'b0, bus_if.bus_ready}, 32'd0);
    check("rst_busy",  {31'b0, bus_if.bus_busy},  32'd0);
    check("rst_error", {31'b0, bus_if.bus_error}, 32'd0);
    check("rst_rdata", bus_if.bus_data_read, 32'd0);
    reset = 1'b1;

    access("init0", 1'b1, 32'h0, 32'hCAFE_F00D, 0);

    // 1: write then read back with WS wait states
    access("t1_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    access("t1_rd", 1'b0, 32'h10, 32'h0, 0);

    // 2: slow release, then immediate follow-up; top word of the window
    access("t2_rd", 1'b0, 32'h10, 32'h0, 4);
    access("t2_wr_top", 1'b1, BASE + DEPTH * 4 - 4, 32'h0BAD_F00D, 1);
    access("t2_rd_top", 1'b0, BASE + DEPTH * 4 - 4, 32'h0, 0);

    // 3: just outside the window
    access("t3_rd_oob", 1'b0, BASE + DEPTH * 4, 32'h0, 0);
    access("t3_wr_oob", 1'b1, BASE + DEPTH * 4, 32'h1234_5678, 0);
    access("t3_rd_0", 1'b0, 32'h0, 32'h0, 0);

    // 4: byte-lane bits ignored
    access("t4_wr", 1'b1, 32'h13, 32'hA5A5_A5A5, 0);
    access("t4_rd", 1'b0, 32'h10, 32'h0, 0);

    // 5: abort in WAIT
    access("t5_pre", 1'b1, 32'h20, 32'h0000_0055, 0);
    @(negedge clock);
    bus_if.bus_vaild        = 1'b1;
    bus_if.bus_write_enable = 1'b1;
    bus_if.bus_address      = 32'h20;
    bus_if.bus_data_write   = 32'h1;
    @(negedge clock);
    check("t5_busy_accept", {31'b0, bus_if.bus_busy}, 32'd1);
    @(negedge clock);
    bus_if.bus_vaild = 1'b0;
    @(negedge clock);
    check("t5_busy_abort", {31'b0, bus_if.bus_busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_ready", {31'b0, bus_if.bus_ready}, 32'd0);
      @(negedge clock);
    end
    access("t5_rd", 1'b0, 32'h20, 32'h0, 0);

    // 6: reset during WAIT of a pending write
    @(negedge clock);
    bus_if.bus_vaild        = 1'b1;
    bus_if.bus_write_enable = 1'b1;
    bus_if.bus_address      = 32'h10;
    bus_if.bus_data_write   = 32'h1111_1111;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_ready", {31'b0, bus_if.bus_ready}, 32'd0);
    check("t6_busy",  {31'b0, bus_if.bus_busy},  32'd0);
    check("t6_error", {31'b0, bus_if.bus_error}, 32'd0);
    check("t6_rdata", bus_if.bus_data_read, 32'd0);
    last_read        = '0;
    bus_if.bus_vaild = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    access("t6_rd", 1'b0, 32'h10, 32'h0, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
